// File: rtl/carregador_cromossomo.sv
// Serial chromosome loader: assembles a byte stream into a shadow register and
// commits the complete chromosome atomically to the fenotipo configuration bus.
module carregador_cromossomo #(
    parameter int unsigned CHROM_BITS = 453,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned N_BYTES    = 57
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [BYTE_W-1:0]                 byte_in,
    input  logic                              byte_valid,
    output logic                              byte_ready,
    output logic [$clog2(N_BYTES)-1:0]        byte_count,
    output logic [CHROM_BITS-1:0]             cromossomo,
    output logic                              crom_valid,
    output logic                              load_done
);

    localparam int unsigned CNT_W = $clog2(N_BYTES);
    localparam int unsigned SH_W  = $clog2(CHROM_BITS);
    localparam int unsigned BIT_W = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                  state;
    logic [CHROM_BITS-1:0]   shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            cromossomo <= '0;
            crom_valid <= 1'b0;
            load_done  <= 1'b0;
            byte_ready <= 1'b0;
            byte_count <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        byte_count <= '0;
                        byte_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    // start has priority over a byte offered in the same cycle
                    if (start) begin
                        byte_count <= '0;
                    end else if (byte_valid && byte_ready) begin
                        // bits beyond CHROM_BITS in the final byte fall outside the loop and are dropped
                        for (int b = 0; b < int'(CHROM_BITS); b++) begin
                            if (b / int'(BYTE_W) == int'(byte_count)) begin
                                shadow[SH_W'(b)] <= byte_in[BIT_W'(b % int'(BYTE_W))];
                            end
                        end
                        if (byte_count == LAST_BYTE) begin
                            state      <= COMMIT;
                            byte_ready <= 1'b0;
                            byte_count <= '0;
                        end else begin
                            byte_count <= byte_count + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    cromossomo <= shadow;
                    crom_valid <= 1'b1;
                    load_done  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_cromossomo.sv
// Bench for carregador_cromossomo: byte-array reference model compared every cycle,
// plus hand-computed expectations for slices, pulse timing and reset behaviour.
module tb_carregador_cromossomo;

    localparam int NB = 57;
    localparam int CB = 453;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [5:0]    byte_count;
    logic [CB-1:0] cromossomo;
    logic          crom_valid;
    logic          load_done;

    int checks = 0;
    int failures = 0;

    carregador_cromossomo dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_count (byte_count),
        .cromossomo (cromossomo),
        .crom_valid (crom_valid),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Stimulus byte patterns, indexed by byte position
    function automatic logic [7:0] pat(input int kind, input int k);
        case (kind)
            0:       return 8'(k);
            1:       return 8'hA5 ^ 8'(k);
            2:       return 8'(8'h3C + 7 * k);
            3:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [CB-1:0] exp_chrom(input int kind);
        logic [CB-1:0] r;
        logic [7:0]    b;
        r = '0;
        for (int i = 0; i < CB; i++) begin
            b = pat(kind, i / 8);
            r[i] = b[i % 8];
        end
        return r;
    endfunction

    // Reference model: collects accepted bytes and builds the chromosome at commit
    int            m_mode = 0;   // 0 idle, 1 loading, 2 committing
    int            m_cnt = 0;
    logic [7:0]    m_bytes [NB];
    logic [CB-1:0] m_crom = '0;
    logic          m_valid = 1'b0;
    logic          m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_crom = '0; m_valid = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: if (start) begin m_mode = 1; m_cnt = 0; end
                1: begin
                    if (start) m_cnt = 0;
                    else if (byte_valid) begin
                        m_bytes[m_cnt] = byte_in;
                        m_cnt++;
                        if (m_cnt == NB) begin m_mode = 2; m_cnt = 0; end
                    end
                end
                default: begin
                    for (int i = 0; i < CB; i++) m_crom[i] = m_bytes[i / 8][i % 8];
                    m_valid = 1'b1; m_done = 1'b1; m_mode = 0;
                end
            endcase
        end
    end

    logic          chk_en = 1'b0;
    logic          hold_chk = 1'b0;
    logic [CB-1:0] hold_val = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("byte_ready", CB'(byte_ready), CB'(m_mode == 1));
            check("byte_count", CB'(byte_count), CB'(m_cnt));
            check("cromossomo", cromossomo, m_crom);
            check("crom_valid", CB'(crom_valid), CB'(m_valid));
            check("load_done", CB'(load_done), CB'(m_done));
            if (hold_chk) begin
                check("hold_crom", cromossomo, hold_val);
                check("hold_valid", CB'(crom_valid), CB'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int to;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                tick();
            end
        end
        byte_in = b;
        byte_valid = 1'b1;
        to = 0;
        while (!byte_ready && to < 100) begin tick(); to++; end
        if (to >= 100) begin
            checks++; failures++;
            $display("FAIL byte_ready_timeout actual=0 expected=1 t=%0t", $time);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    // Called in the cycle after the last byte was accepted (the COMMIT cycle)
    task automatic finish_commit();
        check("commit_ready", CB'(byte_ready), CB'(0));
        check("commit_done_early", CB'(load_done), CB'(0));
        tick();
        hold_chk = 1'b0;
        check("done_pulse", CB'(load_done), CB'(1));
        check("done_valid", CB'(crom_valid), CB'(1));
        tick();
        check("done_clear", CB'(load_done), CB'(0));
    endtask

    task automatic load(input int kind, input bit gaps);
        do_start();
        check("ready_after_start", CB'(byte_ready), CB'(1));
        for (int k = 0; k < NB; k++) send(pat(kind, k), gaps);
        finish_commit();
    endtask

    initial begin
        // Reset with random inputs, byte_valid forced high on the second cycle
        start = 1'($urandom); byte_in = 8'($urandom); byte_valid = 1'b1;
        tick();
        chk_en = 1'b1;
        start = 1'($urandom); byte_in = 8'($urandom); byte_valid = 1'b1;
        tick();
        check("rst_ready", CB'(byte_ready), CB'(0));
        check("rst_count", CB'(byte_count), CB'(0));
        check("rst_crom", cromossomo, '0);
        check("rst_valid", CB'(crom_valid), CB'(0));
        check("rst_done", CB'(load_done), CB'(0));
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
        tick();

        // Gap-free ramp load
        load(0, 1'b0);
        check("ramp_b0", CB'(cromossomo[7:0]), CB'(8'h00));
        check("ramp_b1", CB'(cromossomo[15:8]), CB'(8'h01));
        check("ramp_b55", CB'(cromossomo[447:440]), CB'(8'h37));
        check("ramp_last", CB'(cromossomo[452:448]), CB'(5'h18));

        // Backpressure with random gaps
        load(1, 1'b1);
        check("bp_full", cromossomo, exp_chrom(1));
        check("bp_b0", CB'(cromossomo[7:0]), CB'(8'hA5));
        check("bp_b1", CB'(cromossomo[15:8]), CB'(8'hA4));
        check("bp_last", CB'(cromossomo[452:448]), CB'(5'h1D));

        // Previous chromosome must hold until the next commit edge
        hold_val = exp_chrom(1);
        hold_chk = 1'b1;
        load(2, 1'b0);
        check("reload_full", cromossomo, exp_chrom(2));

        // Restart mid-load: start beats a simultaneous byte
        do_start();
        for (int k = 0; k < 20; k++) send(8'hFF, 1'b0);
        check("pre_restart_count", CB'(byte_count), CB'(20));
        start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
        tick();
        start = 1'b0; byte_valid = 1'b0;
        check("restart_count", CB'(byte_count), CB'(0));
        check("restart_ready", CB'(byte_ready), CB'(1));
        for (int k = 0; k < NB; k++) send(8'h00, 1'b0);
        finish_commit();
        check("restart_crom", cromossomo, '0);

        // Reset mid-load, then a normal load
        do_start();
        for (int k = 0; k < 30; k++) send(pat(0, k), 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", CB'(byte_ready), CB'(0));
        check("mid_rst_count", CB'(byte_count), CB'(0));
        check("mid_rst_crom", cromossomo, '0);
        check("mid_rst_valid", CB'(crom_valid), CB'(0));
        check("mid_rst_done", CB'(load_done), CB'(0));
        rst = 1'b0;
        tick();
        load(0, 1'b0);
        check("post_rst_full", cromossomo, exp_chrom(0));
        check("post_rst_last", CB'(cromossomo[452:448]), CB'(5'h18));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
